// File: rtl/pool_pkg.sv
// Shared widths and the round-robin grant helper for the Pool multiplier arbiter.
package pool_pkg;

  localparam int POOL_A_W     = 16;
  localparam int POOL_B_W     = 16;
  localparam int POOL_P_W     = 32;
  localparam int POOL_MAX_REQ = 8;

  // One-hot grant: first set bit of req searching ptr, ptr+1, ... mod n.
  function automatic logic [POOL_MAX_REQ-1:0] onehot_rr(
    input logic [POOL_MAX_REQ-1:0] req,
    input logic [2:0]              ptr,
    input int                      n
  );
    logic [POOL_MAX_REQ-1:0] g;
    logic                    found;
    int                      idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < POOL_MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/pool_mul_pipe.sv
// MUL_LAT-deep signed x unsigned multiplier carrying a requester tag.
// Operands register in stage 0; the product registers through the rest.
module pool_mul_pipe
  import pool_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 2
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                en,
  input  logic                in_vld,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [POOL_A_W-1:0] a,
  input  logic [POOL_B_W-1:0] b,
  output logic                out_vld,
  output logic [TAG_W-1:0]    out_tag,
  output logic [POOL_P_W-1:0] p,
  output logic                any_vld
);

  logic [MUL_LAT-1:0]  vld_q;
  logic [TAG_W-1:0]    tag_q [MUL_LAT];
  logic [POOL_A_W-1:0] a_q;
  logic [POOL_B_W-1:0] b_q;
  logic [POOL_P_W-1:0] prod;

  assign prod = POOL_P_W'($signed(a_q))
              * POOL_P_W'($signed({1'b0, b_q}));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
    end else if (en) begin
      vld_q[0] <= in_vld;
      tag_q[0] <= in_tag;
      a_q      <= a;
      b_q      <= b;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  generate
    if (MUL_LAT == 1) begin : g_p1
      assign p = prod;
    end else begin : g_pn
      logic [POOL_P_W-1:0] p_q [MUL_LAT-1];
      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int i = 0; i < MUL_LAT-1; i++) p_q[i] <= '0;
        end else if (en) begin
          p_q[0] <= prod;
          for (int i = 1; i < MUL_LAT-1; i++) p_q[i] <= p_q[i-1];
        end
      end
      assign p = p_q[MUL_LAT-2];
    end
  endgenerate

  assign out_vld = vld_q[MUL_LAT-1];
  assign out_tag = tag_q[MUL_LAT-1];
  assign any_vld = |vld_q;

endmodule

// File: rtl/pool_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among N_REQ requesters.
// A stalled result at the output freezes the pipe and blocks new grants.
module pool_mul_arbiter
  import pool_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      res_valid,
  output logic [POOL_P_W-1:0]   res_p,
  input  logic [N_REQ-1:0]      res_ready,
  output logic                  busy
);

  localparam int TAG_W = $clog2(N_REQ);

  logic [TAG_W-1:0]        rr_ptr_q;
  logic                    init_q;
  logic [POOL_MAX_REQ-1:0] req_ext;
  logic [POOL_MAX_REQ-1:0] gnt_ext;
  logic [N_REQ-1:0]        gnt_oh;
  logic [TAG_W-1:0]        gnt_idx;
  logic [POOL_A_W-1:0]     sel_a;
  logic [POOL_B_W-1:0]     sel_b;
  logic                    out_vld;
  logic [TAG_W-1:0]        out_tag;
  logic [POOL_P_W-1:0]     p;
  logic                    any_vld;
  logic                    stall;
  logic                    advance;
  logic                    fire;

  always_comb begin
    req_ext = '0;
    for (int i = 0; i < N_REQ; i++) req_ext[i] = req_valid[i];
    gnt_ext = onehot_rr(req_ext, 3'(rr_ptr_q), N_REQ);
    gnt_oh  = gnt_ext[N_REQ-1:0];
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt_oh[i]) gnt_idx = TAG_W'(i);
    sel_a = req_a[16*gnt_idx +: 16];
    sel_b = req_b[16*gnt_idx +: 16];
  end

  assign stall   = out_vld & ~res_ready[out_tag];
  // No grants during reset or the cycle right after it.
  assign advance = ~stall & ~ap_rst & ~init_q;
  assign req_ready = gnt_oh & {N_REQ{advance}};
  assign fire    = |req_ready;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr_q <= '0;
      init_q   <= 1'b1;
    end else begin
      init_q <= 1'b0;
      if (fire)
        rr_ptr_q <= (gnt_idx == TAG_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  pool_mul_pipe #(
    .MUL_LAT (MUL_LAT),
    .TAG_W   (TAG_W)
  ) u_pipe (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .en      (~stall),
    .in_vld  (fire),
    .in_tag  (gnt_idx),
    .a       (sel_a),
    .b       (sel_b),
    .out_vld (out_vld),
    .out_tag (out_tag),
    .p       (p),
    .any_vld (any_vld)
  );

  always_comb begin
    res_valid = '0;
    if (out_vld && !ap_rst) res_valid[out_tag] = 1'b1;
  end

  assign res_p = ap_rst ? '0 : p;
  assign busy  = any_vld & ~ap_rst;

endmodule

// File: tb/tb_pool_mul_arbiter.sv
// Directed bench for pool_mul_arbiter: grants, latency, extremes, stall, reset.
module tb_pool_mul_arbiter;

  localparam int N = 4;
  localparam int L = 3;

  logic            ap_clk = 1'b0;
  logic            ap_rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_a = '0;
  logic [16*N-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    res_valid;
  logic [31:0]     res_p;
  logic [N-1:0]    res_ready = '1;
  logic            busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  pool_mul_arbiter #(.N_REQ(N), .MUL_LAT(L)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_p     (res_p),
    .res_ready (res_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic setop(input int i, input logic [15:0] a,
                       input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic do_reset;
    ap_rst    = 1'b1;
    req_valid = '0;
    nxt;
    ap_rst = 1'b0;
    nxt;
  endtask

  initial begin
    // reset state, with requests pending
    req_valid = 4'b1111;
    nxt;
    nxt;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_resv",  32'(res_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_resp",  res_p, 0);
    ap_rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 0);
    chk("post_rst_busy",  32'(busy), 0);
    nxt;

    // 1: single request
    setop(0, 16'hFFFD, 16'hFFFF);
    req_valid = 4'b0001;
    #1 chk("t1_grant", 32'(req_ready), 32'b0001);
    nxt;
    req_valid = '0;
    #1 chk("t1_busy", 32'(busy), 1);
    chk("t1_early", 32'(res_valid), 0);
    nxt;
    #1 chk("t1_early2", 32'(res_valid), 0);
    nxt;
    #1 chk("t1_resv", 32'(res_valid), 32'b0001);
    chk("t1_resp", res_p, -196605);
    nxt;
    #1 chk("t1_idle", 32'(busy), 0);

    // 2: all requesting, round-robin order
    do_reset;
    for (int i = 0; i < N; i++)
      setop(i, 16'(10 + i), 16'(1000 + i));
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 8)
        chk("t2_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= L) begin
        chk("t2_resv", 32'(res_valid), 32'(1 << ((k - L) % 4)));
        chk("t2_resp", res_p,
            32'((10 + (k - L) % 4) * (1000 + (k - L) % 4)));
      end
      nxt;
    end
    #1 chk("t2_drain", 32'(res_valid), 0);

    // 3: extremes
    setop(0, 16'h8000, 16'hFFFF);
    req_valid = 4'b0001;
    #1 chk("t3_grant0", 32'(req_ready), 32'b0001);
    nxt;
    setop(0, 16'h7FFF, 16'hFFFF);
    #1 chk("t3_grant1", 32'(req_ready), 32'b0001);
    nxt;
    req_valid = '0;
    nxt;
    #1 chk("t3_min_v", 32'(res_valid), 32'b0001);
    chk("t3_min", res_p, -2147450880);
    nxt;
    #1 chk("t3_max", res_p, 2147385345);
    nxt;

    // 4: stall on requester 1
    do_reset;
    setop(0, 16'd2, 16'd3);
    setop(1, 16'hFFFB, 16'd7);
    setop(2, 16'd100, 16'd200);
    setop(3, 16'd7, 16'd9);
    req_valid = 4'b0111;
    #1 chk("t4_g0", 32'(req_ready), 32'b0001);
    nxt;
    #1 chk("t4_g1", 32'(req_ready), 32'b0010);
    nxt;
    #1 chk("t4_g2", 32'(req_ready), 32'b0100);
    nxt;
    req_valid = '0;
    #1 chk("t4_r0", res_p, 6);
    nxt;
    res_ready = 4'b1101;
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_hold_v", 32'(res_valid), 32'b0010);
      chk("t4_hold_p", res_p, -35);
      chk("t4_noready", 32'(req_ready), 0);
      nxt;
    end
    res_ready = 4'b1111;
    #1 chk("t4_rel_v", 32'(res_valid), 32'b0010);
    chk("t4_rel_g3", 32'(req_ready), 32'b1000);
    nxt;
    req_valid = '0;
    #1 chk("t4_r2_v", 32'(res_valid), 32'b0100);
    chk("t4_r2_p", res_p, 20000);
    nxt;
    #1 chk("t4_gap", 32'(res_valid), 0);
    nxt;
    #1 chk("t4_r3_v", 32'(res_valid), 32'b1000);
    chk("t4_r3_p", res_p, 63);
    nxt;

    // 5: reset with three in flight
    req_valid = 4'b1110;
    #1 chk("t5_g1", 32'(req_ready), 32'b0010);
    nxt;
    nxt;
    nxt;
    req_valid = '0;
    ap_rst = 1'b1;
    #1 chk("t5_rst_v", 32'(res_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    nxt;
    ap_rst = 1'b0;
    req_valid = 4'b1111;
    #1 chk("t5_flush_v", 32'(res_valid), 0);
    chk("t5_flush_busy", 32'(busy), 0);
    chk("t5_init_ready", 32'(req_ready), 0);
    nxt;
    #1 chk("t5_next_g", 32'(req_ready), 32'b0001);
    nxt;
    req_valid = '0;
    #1 chk("t5_none", 32'(res_valid), 0);
    nxt;
    #1 chk("t5_none2", 32'(res_valid), 0);
    nxt;

    // 6: result accepted while req2 is granted
    req_valid = 4'b0100;
    #1 chk("t6_out_v", 32'(res_valid), 32'b0001);
    chk("t6_out_p", res_p, 6);
    chk("t6_grant", 32'(req_ready), 32'b0100);
    nxt;
    req_valid = '0;
    #1 chk("t6_w1", 32'(res_valid), 0);
    nxt;
    #1 chk("t6_w2", 32'(res_valid), 0);
    nxt;
    #1 chk("t6_r2_v", 32'(res_valid), 32'b0100);
    chk("t6_r2_p", res_p, 20000);
    nxt;
    #1 chk("t6_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
